regfile_mp: RTL

- Parametrised multi-port general register file for the pipelined CPU, succeeding the fixed 2-read/1-write file.
- Configurable read and write port counts, register count and data width.
- Built-in pending-write scoreboard so decode can detect RAW hazards without a separate tracking block.
- Keeps the debug tap on a single register (e.g. $28 for board display).

---
 rtl/cpu_pkg.sv | 19 +
 rtl/regfile_mp_if.sv | 42 ++++
 rtl/reg_scoreboard.sv | 43 ++++
 rtl/regfile_mp.sv | 101 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU constants and register-file types.
//   DEF_DATA_W / DEF_ADDR_W : default register width / register address width
//   REG_ZERO                : hard-wired zero register index
//   REG_DBG                 : register shown on the board debug display
//   reg_addr_t / reg_data_t : register address / data at the default widths
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int REG_ZERO   = 0;
   localparam int REG_DBG    = 28;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundle of all register-file signals other than clk/rst.
//   raddr/rdata/rpend : NUM_RD packed read ports (port k at [k*W +: W])
//   we/waddr/wdata    : NUM_WR packed write ports (higher index = later stage)
//   iss_vld/iss_addr  : destination of an instruction issued by decode
//   flush             : clears every pending bit
//   dbg_data          : contents of the debug register
// master = pipeline side, slave = register file.
//
// Handshake semantics: there is no ready signal anywhere on this bus. Each
// write enable and iss_vld is a single-cycle qualifier that the register file
// always accepts on the rising edge it is sampled high; a pulse held for N
// cycles acts N times. Reads are combinational and unqualified.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rpend;
   logic [NUM_WR-1:0]        we;
   logic [NUM_WR*ADDR_W-1:0] waddr;
   logic [NUM_WR*DATA_W-1:0] wdata;
   logic                     iss_vld;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;
   logic [DATA_W-1:0]        dbg_data;

   modport master (
      output raddr, we, waddr, wdata, iss_vld, iss_addr, flush,
      input  rdata, rpend, dbg_data
   );

   modport slave (
      input  raddr, we, waddr, wdata, iss_vld, iss_addr, flush,
      output rdata, rpend, dbg_data
   );
endinterface

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per register marking an outstanding producer.
//   clk, rst (async active-low), we/waddr (retiring writes), iss_vld/iss_addr
//   (new producer), flush (clear all), pend (registered pending vector).
// Priority per edge: flush < write-clear < issue-set. Register 0 never pends.
// -----------------------------------------------------------------------------
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic                     iss_vld,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush,
   output logic [2**ADDR_W-1:0]     pend
);

   logic [2**ADDR_W-1:0] pend_nxt;

   always_comb begin
      pend_nxt = flush ? '0 : pend;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j] && waddr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))
            pend_nxt[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      // Applied last so a new producer supersedes a retiring write or flush.
      if (iss_vld && iss_addr != ADDR_W'(REG_ZERO))
         pend_nxt[iss_addr] = 1'b1;
      pend_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend <= '0;
      else      pend <= pend_nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port general register file with built-in RAW pending scoreboard.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset (clears registers and pending)
//   bus (slave)  : read ports, write ports, issue/flush, debug tap
// Register 0 reads 0 and ignores writes. Same-cycle write collisions resolve
// to the highest-index write port.
// Optional build macro REGFILE_MP_BYPASS_EN: reads and dbg_data forward a
// same-cycle write's data (and drop rpend) instead of the pre-edge contents.
// -----------------------------------------------------------------------------
module regfile_mp
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 2,
   parameter int DBG_REG = REG_DBG
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   localparam int              NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DBG_REG);

   logic [DATA_W-1:0]        regs [NUM_REGS];
   logic [NUM_REGS-1:0]      pend;
   logic [NUM_WR-1:0]        wr_act;
   logic [NUM_RD*DATA_W-1:0] rdata_c;
   logic [NUM_RD-1:0]        rpend_c;
   logic [DATA_W-1:0]        dbg_c;

   // A write port is live only with a non-zero destination.
   always_comb begin
      wr_act = '0;
      for (int j = 0; j < NUM_WR; j++)
         wr_act[j] = bus.we[j] && (bus.waddr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
   end

   // Ascending port loop: the last NBA to an address (highest port) wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_act[j])
               regs[bus.waddr[j*ADDR_W +: ADDR_W]] <= bus.wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   reg_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .iss_vld  (bus.iss_vld),
      .iss_addr (bus.iss_addr),
      .flush    (bus.flush),
      .pend     (pend)
   );

   always_comb begin
      logic [ADDR_W-1:0] ra;
      ra      = '0;
      rdata_c = '0;
      rpend_c = '0;
      dbg_c   = regs[DBG_A];
      for (int k = 0; k < NUM_RD; k++) begin
         ra = bus.raddr[k*ADDR_W +: ADDR_W];
         rdata_c[k*DATA_W +: DATA_W] = regs[ra];
         rpend_c[k]                  = pend[ra];
`ifdef REGFILE_MP_BYPASS_EN
         // Forwarding is suppressed in reset so outputs stay 0 there.
         for (int j = 0; j < NUM_WR; j++) begin
            if (rst && wr_act[j] && bus.waddr[j*ADDR_W +: ADDR_W] == ra) begin
               rdata_c[k*DATA_W +: DATA_W] = bus.wdata[j*DATA_W +: DATA_W];
               rpend_c[k]                  = 1'b0;
            end
         end
`endif
      end
`ifdef REGFILE_MP_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
         if (rst && wr_act[j] && bus.waddr[j*ADDR_W +: ADDR_W] == DBG_A)
            dbg_c = bus.wdata[j*DATA_W +: DATA_W];
      end
`endif
   end

   assign bus.rdata    = rdata_c;
   assign bus.rpend    = rpend_c;
   assign bus.dbg_data = dbg_c;

endmodule
